// File: rtl/arbitro_memoria.sv
// rtl/arbitro_memoria.sv - two-port round-robin arbiter and sequencer for the L1/L2 memory hierarchy
// One transaction at a time: latch winner, strobe once, wait hit-dependent latency, then ack.
module arbitro_memoria #(
  parameter int L1_LAT   = 1,
  parameter int L2_LAT   = 3,
  parameter int MISS_LAT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [15:0] mem_address,
  output logic [15:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [15:0] mem_read_data,
  input  logic        hit_L1,
  input  logic        hit_L2,
  output logic        grant,
  output logic        busy
);

  localparam int MAX_LAT = (L1_LAT > L2_LAT) ? ((L1_LAT > MISS_LAT) ? L1_LAT : MISS_LAT)
                                             : ((L2_LAT > MISS_LAT) ? L2_LAT : MISS_LAT);
  localparam int CW = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_EVAL,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          we_q, we_d;
  logic          grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata0_q, rdata0_d;
  logic [15:0]   rdata1_q, rdata1_d;
  logic          winner;
  logic          win_we;

  // On a tie the port that was not served last wins; otherwise the lone requester.
  assign winner = (req0 & req1) ? ~last_grant_q : ~req0;
  assign win_we = winner ? we1 : we0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    grant_d      = grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          grant_d     = winner;
          we_d        = win_we;
          addr_d      = winner ? addr1 : addr0;
          wdata_d     = winner ? wdata1 : wdata0;
          mem_read_d  = ~win_we;
          mem_write_d = win_we;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_EVAL;
      S_EVAL: begin
        if (hit_L1)      cnt_d = CW'(L1_LAT);
        else if (hit_L2) cnt_d = CW'(L2_LAT);
        else             cnt_d = CW'(MISS_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Ack and read data are registered on the edge into RESP so they appear together.
        if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          cnt_d   = '0;
          state_d = S_RESP;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          if (!we_q) begin
            if (grant_q) rdata1_d = mem_read_data;
            else         rdata0_d = mem_read_data;
          end
        end
      end
      S_RESP: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign grant          = grant_q;
  assign busy           = busy_q;

endmodule
